cpu_bus_serializer: RTL and testbench
=====================================

CPU_BUS_SERIALIZER -- requirements
Module: cpu_bus_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, CPU address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, CPU data width in bits.
REQ-003 SHALL have parameter LANE_W, default 8, pin lane width in bits; ADDR_BEATS=ADDR_W/LANE_W, DATA_BEATS=DATA_W/LANE_W.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  transaction request, sampled only in IDLE.
REQ-007 cpu_we  in  1  1=write, 0=read; latched with cpu_req.
REQ-008 cpu_addr  in  ADDR_W  transaction address; latched with cpu_req.
REQ-009 cpu_wdata  in  DATA_W  write data; latched with cpu_req.
REQ-010 cpu_ready  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1, held until next read completes.
REQ-012 pin_addr_out  out  LANE_W  address lane / command beat.
REQ-013 pin_data_out  out  LANE_W  write-data lane.
REQ-014 pin_data_in  in  LANE_W  read-data lane.
REQ-015 pin_oe  out  LANE_W  data-pin output enable, all-ones or all-zeros.
REQ-016 pin_frame  out  1  high for every beat of a transaction.
REQ-017 pin_wait  in  1  external stall; holds current beat.

Function
REQ-018 States: IDLE, ADDR, CMD, TURN, RDATA, DONE.
REQ-019 IDLE: on cpu_req=1 latch cpu_we/addr/wdata, enter ADDR with beat index 0; cpu_req=0 stays IDLE.
REQ-020 ADDR: beat k drives pin_addr_out=addr lane k (LSB lane first); for writes pin_data_out=wdata lane k and pin_oe all-ones when k<DATA_BEATS, zero otherwise; after beat ADDR_BEATS-1 enter CMD.
REQ-021 CMD: one beat, pin_addr_out bit0=we, bit1=1, other bits 0; pin_oe 0; write -> DONE, read -> TURN.
REQ-022 TURN: one beat, pin_oe 0, pins 0; then RDATA index 0.
REQ-023 RDATA: beat k captures pin_data_in into rdata lane k (LSB first); after beat DATA_BEATS-1 enter DONE.
REQ-024 DONE: cpu_ready=1 for exactly one cycle, pin_frame=0, then IDLE; cpu_req held high is re-accepted only from IDLE (min one IDLE cycle between transactions).
REQ-025 pin_frame=1 in ADDR, CMD, TURN, RDATA; 0 in IDLE, DONE.
REQ-026 pin_wait=1 in ADDR/CMD/TURN/RDATA: state, beat index and all outputs held, no capture; ignored in IDLE, DONE.
REQ-027 Latency, no wait, acceptance cycle = 0: write cpu_ready at cycle ADDR_BEATS+2; read at cycle ADDR_BEATS+DATA_BEATS+3 (defaults: 6 and 11).
REQ-028 cpu_req/cpu_we/cpu_addr/cpu_wdata changes after acceptance SHALL NOT affect the transaction in flight.
REQ-029 pin_addr_out, pin_data_out, pin_oe SHALL be registered outputs; 0 in IDLE and DONE.
REQ-030 Elaboration SHALL fail if LANE_W does not divide ADDR_W and DATA_W, or LANE_W<2.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, beat index 0, cpu_ready=0, cpu_rdata=0, pin_addr_out=0, pin_data_out=0, pin_oe=0, pin_frame=0.
REQ-032 Reset mid-transaction SHALL abort it with no cpu_ready pulse; first request after deassertion accepted on the first rising edge with rst_n=1.

Structure
REQ-033 Shared package cpu_bus_ser_pkg SHALL hold the state enum and the CMD bit positions (CMD_WE_BIT=0, CMD_MARK_BIT=1).
REQ-034 Beat index SHALL be one sub-module beat_counter (clear, enable, terminal-count compare, parameterised width).

Verification
REQ-035 Write, defaults, addr=0x12345678, wdata=0xCAFEBABE -> pin_addr_out 78,56,34,12, pin_data_out BE,BA,FE,CA, CMD=0x03, cpu_ready at cycle 6.
REQ-036 Read, addr=0x000000A5, pin_data_in 11,22,33,44 on RDATA beats -> CMD=0x02, cpu_rdata=0x44332211, cpu_ready at cycle 11.
REQ-037 Write with pin_wait=1 for 3 cycles at ADDR beat 2 -> beat 2 outputs held 4 cycles, cpu_ready at cycle 9.
REQ-038 rst_n pulsed low during RDATA beat 1 -> all outputs 0 immediately, no cpu_ready, next read completes normally.
REQ-039 cpu_req held high across two transactions -> exactly one IDLE cycle between DONE and next ADDR; second uses values sampled at its own acceptance.
REQ-040 ADDR_W=16, DATA_W=16, LANE_W=4 read -> 4 ADDR beats, 4 RDATA beats, cpu_ready at cycle 11.

Source files
------------

// File: rtl/cpu_bus_ser_pkg.sv
// Shared types and constants for the CPU-to-pin bus serializer.
package cpu_bus_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_TURN,
    ST_RDATA,
    ST_DONE
  } state_t;

  // Command beat layout on pin_addr_out
  localparam int CMD_WE_BIT   = 0;
  localparam int CMD_MARK_BIT = 1;

endpackage

// File: rtl/cpu_bus_serializer_beat_counter.sv
// Beat index counter: synchronous clear, increment enable, terminal-count flag.
module beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_comb begin
    o_count_next = r_count;
    if (i_clear) begin
      o_count_next = '0;
    end else if (i_enable) begin
      o_count_next = r_count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/cpu_bus_serializer.sv
// Serializes a CPU read/write into lane-wide address, command, turnaround
// and read-data beats on a narrow pin bus, with an external wait stall.
module cpu_bus_serializer
  import cpu_bus_ser_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [LANE_W-1:0] pin_addr_out,
  output logic [LANE_W-1:0] pin_data_out,
  input  logic [LANE_W-1:0] pin_data_in,
  output logic [LANE_W-1:0] pin_oe,
  output logic              pin_frame,
  input  logic              pin_wait
);

  localparam int ADDR_BEATS = ADDR_W / LANE_W;
  localparam int DATA_BEATS = DATA_W / LANE_W;
  localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  generate
    if (LANE_W < 2 || (ADDR_W % LANE_W) != 0 || (DATA_W % LANE_W) != 0) begin : g_bad_params
      $error("cpu_bus_serializer: LANE_W must be >= 2 and divide ADDR_W and DATA_W");
    end
  endgenerate

  state_t              r_state, w_state_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rbuf, r_rdata, w_rbuf_next;
  logic [LANE_W-1:0]   r_pin_addr, r_pin_data, r_pin_oe;
  logic [LANE_W-1:0]   w_pin_addr_next, w_pin_data_next, w_pin_oe_next;
  logic                w_clear, w_inc, w_tc;
  logic [CNT_W-1:0]    w_beat, w_beat_next, w_last;
  logic                w_we_src;
  logic [ADDR_W-1:0]   w_addr_src;
  logic [DATA_W-1:0]   w_wdata_src;

  beat_counter #(.W(CNT_W)) u_beat (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_enable     (w_inc),
    .i_last       (w_last),
    .o_count      (w_beat),
    .o_count_next (w_beat_next),
    .o_tc         (w_tc)
  );

  assign w_last = (r_state == ST_ADDR) ? CNT_W'(ADDR_BEATS - 1) : CNT_W'(DATA_BEATS - 1);

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      ST_IDLE: if (cpu_req) begin
        w_state_next = ST_ADDR;
        w_clear      = 1'b1;
      end
      ST_ADDR: if (!pin_wait) begin
        if (w_tc) begin
          w_state_next = ST_CMD;
          w_clear      = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_CMD: if (!pin_wait) begin
        w_state_next = r_we ? ST_DONE : ST_TURN;
      end
      ST_TURN: if (!pin_wait) begin
        w_state_next = ST_RDATA;
        w_clear      = 1'b1;
      end
      ST_RDATA: if (!pin_wait) begin
        if (w_tc) begin
          w_state_next = ST_DONE;
          w_clear      = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The first address beat is registered on the acceptance edge, so it must
  // come straight from the CPU inputs rather than the not-yet-loaded latches.
  assign w_we_src    = (r_state == ST_IDLE) ? cpu_we    : r_we;
  assign w_addr_src  = (r_state == ST_IDLE) ? cpu_addr  : r_addr;
  assign w_wdata_src = (r_state == ST_IDLE) ? cpu_wdata : r_wdata;

  always_comb begin
    w_pin_addr_next = '0;
    w_pin_data_next = '0;
    w_pin_oe_next   = '0;
    case (w_state_next)
      ST_ADDR: begin
        for (int k = 0; k < ADDR_BEATS; k++) begin
          if (int'(w_beat_next) == k) w_pin_addr_next = w_addr_src[k*LANE_W +: LANE_W];
        end
        for (int k = 0; k < DATA_BEATS; k++) begin
          if (w_we_src && int'(w_beat_next) == k) begin
            w_pin_data_next = w_wdata_src[k*LANE_W +: LANE_W];
            w_pin_oe_next   = '1;
          end
        end
      end
      ST_CMD: begin
        w_pin_addr_next[CMD_WE_BIT]   = w_we_src;
        w_pin_addr_next[CMD_MARK_BIT] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rbuf_next = r_rbuf;
    if (r_state == ST_RDATA && !pin_wait) begin
      for (int k = 0; k < DATA_BEATS; k++) begin
        if (int'(w_beat) == k) w_rbuf_next[k*LANE_W +: LANE_W] = pin_data_in;
      end
    end
  end

  // cpu_rdata only moves when a read completes; partial lanes live in r_rbuf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_rdata    <= '0;
      r_pin_addr <= '0;
      r_pin_data <= '0;
      r_pin_oe   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pin_addr <= w_pin_addr_next;
      r_pin_data <= w_pin_data_next;
      r_pin_oe   <= w_pin_oe_next;
      r_rbuf     <= w_rbuf_next;
      if (r_state == ST_IDLE && cpu_req) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (r_state == ST_RDATA && w_state_next == ST_DONE) begin
        r_rdata <= w_rbuf_next;
      end
    end
  end

  assign cpu_ready    = (r_state == ST_DONE);
  assign cpu_rdata    = r_rdata;
  assign pin_addr_out = r_pin_addr;
  assign pin_data_out = r_pin_data;
  assign pin_oe       = r_pin_oe;
  assign pin_frame    = (r_state == ST_ADDR) || (r_state == ST_CMD) ||
                        (r_state == ST_TURN) || (r_state == ST_RDATA);

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Scoreboard bench: stimulus queues expected pin beats and completions, a
// monitor compares them against the serializer every cycle.
module tb_cpu_bus_serializer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int AB = AW / LW;
  localparam int DB = DW / LW;

  typedef struct {
    logic [LW-1:0] a;
    logic [LW-1:0] d;
    logic [LW-1:0] oe;
    logic [LW-1:0] rdLane;
    bit            isRd;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic [LW-1:0] pin_addr_out, pin_data_out, pin_oe;
  logic [LW-1:0] pin_data_in;
  logic          pin_frame;
  logic          pin_wait = 1'b0;

  logic          req2 = 1'b0, we2 = 1'b0, ready2, frame2;
  logic [15:0]   addr2 = '0, wdata2 = '0, rdata2;
  logic [3:0]    pao2, pdo2, oe2;
  logic [3:0]    pdi2 = '0;
  logic          wait2 = 1'b0;

  beat_t         pinQ[$];
  logic [31:0]   txnQ[$];
  logic [31:0]   lastRead = '0;
  bit            readyNext = 1'b0, afterDone = 1'b0;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  cpu_bus_serializer #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .pin_addr_out(pin_addr_out), .pin_data_out(pin_data_out),
    .pin_data_in(pin_data_in), .pin_oe(pin_oe), .pin_frame(pin_frame), .pin_wait(pin_wait)
  );

  cpu_bus_serializer #(.ADDR_W(16), .DATA_W(16), .LANE_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req2), .cpu_we(we2),
    .cpu_addr(addr2), .cpu_wdata(wdata2), .cpu_ready(ready2),
    .cpu_rdata(rdata2), .pin_addr_out(pao2), .pin_data_out(pdo2),
    .pin_data_in(pdi2), .pin_oe(oe2), .pin_frame(frame2), .pin_wait(wait2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every beat the transaction should put on the pins, in order.
  task automatic buildTxn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, output int nrec);
    beat_t b;
    nrec = 0;
    for (int k = 0; k < AB; k++) begin
      b = '{default: '0};
      b.a = addr[k*LW +: LW];
      if (we && k < DB) begin
        b.d  = wdata[k*LW +: LW];
        b.oe = '1;
      end
      pinQ.push_back(b);
      nrec++;
    end
    b = '{default: '0};
    b.a = we ? 8'h03 : 8'h02;
    b.last = we;
    pinQ.push_back(b);
    nrec++;
    if (!we) begin
      b = '{default: '0};
      pinQ.push_back(b);
      nrec++;
      for (int k = 0; k < DB; k++) begin
        b = '{default: '0};
        b.isRd = 1'b1;
        b.rdLane = rdata[k*LW +: LW];
        b.last = (k == DB - 1);
        pinQ.push_back(b);
        nrec++;
      end
      lastRead = rdata;
    end
    txnQ.push_back(lastRead);
  endtask

  // Called at posedge+1 of the acceptance cycle; returns at posedge+1 of the
  // cycle after DONE. Beat j is stalled for wlen cycles starting at cycle j+1.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int wbeat, input int wlen,
                               input bit holdReq);
    int nrec, lat;
    buildTxn(we, addr, wdata, rdata, nrec);
    lat = nrec + 1 + wlen;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    pin_wait = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      #1;
      if (!holdReq) cpu_req = 1'b0;
      cpu_we = 1'($urandom);
      cpu_addr = $urandom;
      cpu_wdata = $urandom;
      pin_wait = (c >= wbeat + 1 && c <= wbeat + wlen) || (c == lat);
      if (c == lat) begin
        @(negedge clk);
        checkOutput("ready_latency", 32'(cpu_ready), 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      pin_wait = 1'($urandom);
      cpu_addr = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetDuringRead(input logic [31:0] addr, input logic [31:0] rdata);
    int nrec;
    buildTxn(1'b0, addr, 32'd0, rdata, nrec);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = addr;
    pin_wait = 1'b0;
    for (int c = 1; c <= AB + 4; c++) begin
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_addr_out", 32'(pin_addr_out), 32'd0);
    checkOutput("rst_data_out", 32'(pin_data_out), 32'd0);
    checkOutput("rst_oe", 32'(pin_oe), 32'd0);
    checkOutput("rst_frame", 32'(pin_frame), 32'd0);
    pinQ.delete();
    txnQ.delete();
    lastRead = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test16();
    logic [15:0] a, d;
    a = 16'h5A3C;
    d = 16'($urandom);
    req2 = 1'b1;
    we2 = 1'b0;
    addr2 = a;
    wdata2 = 16'($urandom);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      req2 = 1'b0;
      addr2 = 16'($urandom);
      pdi2 = (c >= 7 && c <= 10) ? d[(c-7)*4 +: 4] : 4'($urandom);
      @(negedge clk);
      checkOutput("w16_ready", 32'(ready2), 32'(c == 11));
      checkOutput("w16_frame", 32'(frame2), 32'(c <= 10));
      if (c <= 4) checkOutput("w16_addr_beat", 32'(pao2), 32'(a[(c-1)*4 +: 4]));
      if (c == 5) checkOutput("w16_cmd", 32'(pao2), 32'h2);
    end
    checkOutput("w16_rdata", 32'(rdata2), 32'(d));
  endtask

  // Monitor: checks pins against the expected beat queue and completions
  // against the transaction queue; also plays the read-data responder.
  initial begin : monitor
    beat_t h;
    pin_data_in = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        readyNext = 1'b0;
        afterDone = 1'b0;
        continue;
      end
      checkOutput("ready_pulse", 32'(cpu_ready), 32'(readyNext));
      if (readyNext) begin
        if (txnQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rdata: completion with no expected value at %0t", $time);
        end else begin
          checkOutput("rdata", cpu_rdata, txnQ.pop_front());
        end
      end
      if (afterDone) checkOutput("idle_gap_frame", 32'(pin_frame), 32'd0);
      afterDone = readyNext;
      readyNext = 1'b0;
      pin_data_in = LW'($urandom);
      if (pin_frame) begin
        if (pinQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_frame: got 1, expected 0 at %0t", $time);
        end else begin
          h = pinQ[0];
          checkOutput("pin_addr_out", 32'(pin_addr_out), 32'(h.a));
          checkOutput("pin_data_out", 32'(pin_data_out), 32'(h.d));
          checkOutput("pin_oe", 32'(pin_oe), 32'(h.oe));
          if (!pin_wait) begin
            if (h.isRd) pin_data_in = h.rdLane;
            void'(pinQ.pop_front());
            if (h.last) readyNext = 1'b1;
          end
        end
      end else begin
        checkOutput("idle_pins", {8'd0, pin_addr_out, pin_data_out, pin_oe}, 32'd0);
      end
    end
  end

  initial begin : stimulus
    bit rwe, rhold;
    int nb, rwb, rwl;
    @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_pins", {8'd0, pin_addr_out, pin_data_out, pin_oe}, 32'd0);
    checkOutput("reset_frame", 32'(pin_frame), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h12345678, 32'hCAFEBABE, 32'd0, 0, 0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 32'h000000A5, 32'd0, 32'h44332211, 0, 0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 32'h12345678, 32'hCAFEBABE, 32'd0, 2, 3, 1'b0);
    idle(2);
    resetDuringRead(32'h0000BEEF, 32'h99887766);
    applyStimulus(1'b0, 32'h00C0FFEE, 32'd0, 32'hA1B2C3D4, 0, 0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 32'hAAAA5555, 32'h01020304, 32'd0, 0, 0, 1'b1);
    applyStimulus(1'b0, 32'h5555AAAA, 32'd0, 32'hDEADBEEF, 0, 0, 1'b0);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      rwe = 1'($urandom);
      nb = rwe ? AB + 1 : AB + 2 + DB;
      rwb = $urandom_range(0, nb - 1);
      rwl = $urandom_range(0, 3);
      rhold = (n < 39) && ($urandom_range(0, 2) == 0);
      applyStimulus(rwe, $urandom, $urandom, $urandom, rwb, rwl, rhold);
      if (!rhold) idle($urandom_range(0, 2));
    end

    pin_wait = 1'b0;
    idle(3);
    checkOutput("pin_queue_drained", 32'(pinQ.size()), 32'd0);
    checkOutput("txn_queue_drained", 32'(txnQ.size()), 32'd0);
    test16();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
